// File: rtl/csr_spmv_lanes.sv
// rtl/csr_spmv_lanes.sv - CSR sparse matrix x dense multi-column multiply engine
module csr_spmv_lanes #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LANES  = 2,
  parameter int ROW_AW = 10,
  parameter int NNZ_AW = 14,
  parameter int VEC_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_AW-1:0]        num_rows,
  output logic [ROW_AW-1:0]        row_addr,
  input  logic [NNZ_AW-1:0]        row_data,
  output logic [NNZ_AW-1:0]        nz_addr,
  input  logic [DATA_W-1:0]        nz_val,
  input  logic [VEC_AW-1:0]        nz_col,
  output logic [VEC_AW-1:0]        vec_addr,
  input  logic [LANES*DATA_W-1:0]  vec_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_AW-1:0]        out_row,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic                     out_empty,
  output logic                     busy,
  output logic                     done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PTR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

  logic [2:0]                        r_state;
  logic [1:0]                        r_phase;
  logic [ROW_AW-1:0]                 r_num_rows;
  logic [ROW_AW-1:0]                 r_row;
  logic [ROW_AW-1:0]                 r_row_addr;
  logic [NNZ_AW-1:0]                 r_begin;
  logic [NNZ_AW-1:0]                 r_end;
  logic [NNZ_AW-1:0]                 r_nz_addr;
  logic [VEC_AW-1:0]                 r_vec_addr;
  logic                              r_p0, r_p1, r_p2, r_p3;
  logic signed [DATA_W-1:0]          r_val;
  logic signed [DATA_W-1:0]          r_val_d;
  logic [LANES-1:0][ACC_W-1:0]       r_acc;
  logic                              r_out_valid;
  logic                              r_out_empty;
  logic                              r_busy;
  logic                              r_done;

  logic                              w_empty;
  logic                              w_last;
  logic                              w_hs;
  logic                              w_acc_clr;
  logic [LANES-1:0][ACC_W-1:0]       w_ext;

  // A row whose end pointer does not exceed its begin pointer (including corrupt ones) is empty
  assign w_empty   = (row_data <= r_begin);
  assign w_last    = (r_row == r_num_rows - ROW_AW'(1));
  assign w_hs      = r_out_valid & out_ready;
  assign w_acc_clr = ((r_state == S_IDLE) && start && (num_rows != '0)) ||
                     ((r_state == S_EMIT) && w_hs && !w_last);

  // Per-lane signed product, sign-extended to accumulator width
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [2*DATA_W-1:0] w_prod;
    assign w_prod    = (2*DATA_W)'(r_val_d) *
                       (2*DATA_W)'($signed(vec_data[gi*DATA_W +: DATA_W]));
    assign w_ext[gi] = ACC_W'(w_prod);
  end

  // Control FSM: pointer fetch, non-zero issue, pipe drain and result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= 2'd0;
      r_num_rows  <= '0;
      r_row       <= '0;
      r_row_addr  <= '0;
      r_begin     <= '0;
      r_end       <= '0;
      r_nz_addr   <= '0;
      r_p0        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_empty <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_rows == '0) begin
              r_done <= 1'b1;
            end else begin
              r_num_rows <= num_rows;
              r_row      <= '0;
              r_row_addr <= '0;
              r_phase    <= 2'd0;
              r_busy     <= 1'b1;
              r_state    <= S_PTR;
            end
          end
        end
        S_PTR: begin
          case (r_phase)
            2'd0: begin
              r_row_addr <= r_row_addr + ROW_AW'(1);
              r_phase    <= 2'd1;
            end
            2'd1: begin
              // Only the first row needs its own begin pointer; later rows inherit the previous end
              if (r_row == '0) r_begin <= row_data;
              r_phase <= 2'd2;
            end
            default: begin
              r_end <= row_data;
              if (w_empty) begin
                r_out_empty <= 1'b1;
                r_state     <= S_EMIT;
              end else begin
                r_out_empty <= 1'b0;
                r_nz_addr   <= r_begin;
                r_p0        <= 1'b1;
                r_state     <= S_RUN;
              end
            end
          endcase
        end
        S_RUN: begin
          if (r_nz_addr + NNZ_AW'(1) == r_end) begin
            r_p0    <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_nz_addr <= r_nz_addr + NNZ_AW'(1);
          end
        end
        S_DRAIN: begin
          if (!(r_p0 | r_p1 | r_p2 | r_p3)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_begin     <= r_end;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_row      <= r_row + ROW_AW'(1);
              r_row_addr <= r_row + ROW_AW'(2);
              r_phase    <= 2'd1;
              r_state    <= S_PTR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand pipe: capture value/column, look up dense row, align value with vector data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_p3       <= 1'b0;
      r_val      <= '0;
      r_val_d    <= '0;
      r_vec_addr <= '0;
    end else begin
      r_p1    <= r_p0;
      r_p2    <= r_p1;
      r_p3    <= r_p2;
      r_val_d <= r_val;
      if (r_p1) begin
        r_val      <= nz_val;
        r_vec_addr <= nz_col;
      end
    end
  end

  // Lane accumulators: cleared at each row start, wrap modulo 2^ACC_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
    end else if (r_p3) begin
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= r_acc[i] + w_ext[i];
      end
    end
  end

  assign row_addr  = r_row_addr;
  assign nz_addr   = r_nz_addr;
  assign vec_addr  = r_vec_addr;
  assign out_valid = r_out_valid;
  assign out_row   = r_row;
  assign out_data  = r_acc;
  assign out_empty = r_out_empty;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
